// File: rtl/tap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tap_pkg
// Description : Shared types and timing constants for the TAP playback engine.
// Revision    : 1.0 - initial release
// ============================================================================
package tap_pkg;

    // Playback state, explicitly encoded on three bits
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        DONE  = 3'd4
    } tap_state_t;

    // Length of each waveform phase, in timing units
    localparam int HI_UNITS  = 1;
    localparam int LO1_UNITS = 1;
    localparam int LO0_UNITS = 2;

    // Odd parity: data plus parity bit always carries an odd number of ones
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tap_unit_timer.sv
`default_nettype none
// ============================================================================
// Module      : tap_unit_timer
// Description : Divides clk down to one timing unit. Counts 0..UNIT_CYC-1
//               while run is high, freezes while run is low, and returns to 0
//               on clear. unit_tick marks the last cycle of each unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tap_unit_timer #(
    parameter int UNIT_CYC = 4992
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic unit_tick
);

    localparam int CNT_W = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(UNIT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    assign unit_tick = run & (r_cnt == c_LAST);

    // Unit counter: clear wins, otherwise advance only while running
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= unit_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tap_player.sv
`default_nettype none
// ============================================================================
// Module      : tap_player
// Description : Plays TAP bytes from the tape cache as the Oric cassette
//               waveform. Each byte is framed as start(0), 8 data bits LSB
//               first, odd parity and STOP_BITS ones. Every bit is one unit
//               high followed by one ('1') or two ('0') units low. The next
//               byte is prefetched during the stop bits so frames run back
//               to back.
// Revision    : 1.0 - initial release
// ============================================================================
module tap_player
    import tap_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int UNIT_CYC  = 4992,
    parameter int STOP_BITS = 4,
    parameter int READ_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rewind,
    input  logic              en,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] tape_end,
    output logic [ADDR_W-1:0] tape_addr,
    input  logic [7:0]        tape_data,
    output logic              data,
    output logic              busy,
    output logic              at_end
);

    localparam int FRAME_BITS = 10 + STOP_BITS;
    localparam int IDX_W      = $clog2(FRAME_BITS);

    localparam logic [IDX_W-1:0] c_LAST_IDX   = IDX_W'(FRAME_BITS - 1);
    localparam logic [IDX_W-1:0] c_PARITY_IDX = IDX_W'(9);
    localparam logic [1:0]       c_READ_LAT   = 2'(READ_LAT);
    localparam logic [1:0]       c_HI_LEFT    = 2'(HI_UNITS - 1);
    localparam logic [1:0]       c_LO1_LEFT   = 2'(LO1_UNITS - 1);
    localparam logic [1:0]       c_LO0_LEFT   = 2'(LO0_UNITS - 1);

    tap_state_t              r_state;
    logic [FRAME_BITS-1:0]   r_frame;      // bit 0 is the bit on air
    logic [IDX_W-1:0]        r_bit_idx;
    logic [1:0]              r_units_left;
    logic [1:0]              r_lat_cnt;    // shared by FETCH and prefetch
    logic                    r_pf_busy;
    logic [7:0]              r_next_byte;
    logic                    r_more;       // another byte follows this frame
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_data;
    logic                    r_busy;
    logic                    r_at_end;

    logic w_in_bit;
    logic w_tick;
    logic w_timer_run;
    logic w_timer_clr;
    logic w_addr_is_end;

    assign tape_addr = r_addr;
    assign data      = r_data;
    assign busy      = r_busy;
    assign at_end    = r_at_end;

    assign w_in_bit      = (r_state == HI) || (r_state == LO);
    assign w_timer_run   = en & ~rewind & w_in_bit;
    assign w_timer_clr   = rewind | ~w_in_bit;
    assign w_addr_is_end = (r_addr == tape_end);

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] b);
        return {{STOP_BITS{1'b1}}, odd_parity(b), b, 1'b0};
    endfunction

    tap_unit_timer #(
        .UNIT_CYC (UNIT_CYC)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_timer_clr),
        .run       (w_timer_run),
        .unit_tick (w_tick)
    );

    // Playback FSM: fetch, bit framing, prefetch and end-of-tape handling
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_frame      <= '0;
            r_bit_idx    <= '0;
            r_units_left <= '0;
            r_lat_cnt    <= '0;
            r_pf_busy    <= 1'b0;
            r_next_byte  <= '0;
            r_more       <= 1'b0;
            r_addr       <= '0;
            r_data       <= 1'b1;
            r_busy       <= 1'b0;
            r_at_end     <= 1'b0;
        end else if (rewind) begin
            r_state      <= IDLE;
            r_bit_idx    <= '0;
            r_units_left <= '0;
            r_lat_cnt    <= '0;
            r_pf_busy    <= 1'b0;
            r_more       <= 1'b0;
            r_addr       <= '0;
            r_data       <= 1'b1;
            r_busy       <= 1'b0;
            r_at_end     <= 1'b0;
        end else if (en) begin
            // Background capture of the prefetched byte; state branches below
            // may override r_lat_cnt when they restart it.
            if (r_pf_busy) begin
                if (r_lat_cnt == c_READ_LAT) begin
                    r_next_byte <= tape_data;
                    r_pf_busy   <= 1'b0;
                end else begin
                    r_lat_cnt <= r_lat_cnt + 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    r_state   <= FETCH;
                    r_busy    <= 1'b1;
                    r_lat_cnt <= '0;
                end

                FETCH: begin
                    if (r_lat_cnt == c_READ_LAT) begin
                        r_frame      <= build_frame(tape_data);
                        r_bit_idx    <= '0;
                        r_units_left <= c_HI_LEFT;
                        r_state      <= HI;
                        r_data       <= 1'b1;
                        r_pf_busy    <= 1'b0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end

                HI: begin
                    if (w_tick) begin
                        if (r_units_left != '0) begin
                            r_units_left <= r_units_left - 1'b1;
                        end else begin
                            r_state      <= LO;
                            r_data       <= 1'b0;
                            r_units_left <= r_frame[0] ? c_LO1_LEFT : c_LO0_LEFT;
                        end
                    end
                end

                LO: begin
                    if (w_tick) begin
                        if (r_units_left != '0) begin
                            r_units_left <= r_units_left - 1'b1;
                        end else if (r_bit_idx == c_LAST_IDX) begin
                            if (!r_more) begin
                                r_state  <= DONE;
                                r_data   <= 1'b1;
                                r_busy   <= 1'b0;
                                r_at_end <= 1'b1;
                            end else if (r_pf_busy) begin
                                // Prefetch still in flight: finish it as a fetch
                                r_state <= FETCH;
                                r_data  <= 1'b1;
                            end else begin
                                r_frame      <= build_frame(r_next_byte);
                                r_bit_idx    <= '0;
                                r_units_left <= c_HI_LEFT;
                                r_state      <= HI;
                                r_data       <= 1'b1;
                            end
                        end else begin
                            r_frame      <= r_frame >> 1;
                            r_bit_idx    <= r_bit_idx + 1'b1;
                            r_units_left <= c_HI_LEFT;
                            r_state      <= HI;
                            r_data       <= 1'b1;
                            // Entering the first stop bit: move to the next byte
                            if (r_bit_idx == c_PARITY_IDX) begin
                                if (w_addr_is_end && !loop_en) begin
                                    r_more <= 1'b0;
                                end else begin
                                    r_addr    <= w_addr_is_end ? '0 : r_addr + 1'b1;
                                    r_more    <= 1'b1;
                                    r_pf_busy <= 1'b1;
                                    r_lat_cnt <= '0;
                                end
                            end
                        end
                    end
                end

                DONE: begin
                    r_data <= 1'b1;
                    r_busy <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tap_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_tap_player
// Description : Self-checking bench for tap_player. A waveform model builds
//               the expected per-cycle data/address stream from the framing
//               and timing rules; the DUT is compared against it every cycle
//               under directed and randomised tapes, pauses and rewinds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tap_player;

    localparam int U  = 4;
    localparam int SB = 4;
    localparam int RL = 1;
    localparam int AW = 16;
    localparam int FB = 10 + SB;

    logic          clk = 1'b0;
    logic          reset;
    logic          rewind;
    logic          en;
    logic          loop_en;
    logic [AW-1:0] tape_end;
    logic [AW-1:0] tape_addr;
    logic [7:0]    tape_data;
    logic          data;
    logic          busy;
    logic          at_end;

    always #5 clk = ~clk;

    // Tape cache model with READ_LAT register stages
    logic [7:0] mem     [0:255];
    logic [7:0] rd_pipe [0:RL-1];

    always @(posedge clk) begin
        rd_pipe[0] <= mem[tape_addr[7:0]];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign tape_data = rd_pipe[RL-1];

    tap_player #(
        .ADDR_W    (AW),
        .UNIT_CYC  (U),
        .STOP_BITS (SB),
        .READ_LAT  (RL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rewind    (rewind),
        .en        (en),
        .loop_en   (loop_en),
        .tape_end  (tape_end),
        .tape_addr (tape_addr),
        .tape_data (tape_data),
        .data      (data),
        .busy      (busy),
        .at_end    (at_end)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected stream while playing, and the resting address afterwards
    bit exp_d[$];
    int exp_a[$];
    int tail_a;

    // Decoded bits and busy-cycle count from the last run
    bit dec_q[$];
    int lo_run;
    int busy_cnt;

    task automatic build_model(input int max_len);
        int       addr;
        bit       more;
        bit       v;
        logic [7:0] b;
        exp_d.delete();
        exp_a.delete();
        addr = 0;
        for (int i = 0; i < RL + 1; i++) begin
            exp_d.push_back(1'b1);
            exp_a.push_back(0);
        end
        more = 1'b1;
        while (more && exp_d.size() < max_len) begin
            b = mem[addr[7:0]];
            for (int j = 0; j < FB; j++) begin
                if (j == 0)      v = 1'b0;
                else if (j <= 8) v = b[j-1];
                else if (j == 9) v = ~^b;
                else             v = 1'b1;
                if (j == 10) begin
                    if (addr == int'(tape_end)) begin
                        if (loop_en) addr = 0;
                        else         more = 1'b0;
                    end else begin
                        addr = addr + 1;
                    end
                end
                repeat (U) begin
                    exp_d.push_back(1'b1);
                    exp_a.push_back(addr);
                end
                repeat (v ? U : 2 * U) begin
                    exp_d.push_back(1'b0);
                    exp_a.push_back(addr);
                end
            end
        end
        tail_a = addr;
    endtask

    task automatic restart();
        @(negedge clk);
        en     = 1'b0;
        rewind = 1'b1;
        @(negedge clk);
        rewind = 1'b0;
    endtask

    // Plays from IDLE, comparing every cycle; pauses freeze the expected index
    task automatic run_play(input int ncyc, input int pause_at, input int pause_len,
                            input bit rand_pause, input int rewind_at);
        int k;
        int pause_left;
        int budget;
        bit rw_check;
        bit e_d;
        bit e_b;
        bit e_e;
        int e_a;
        k = 0; pause_left = 0; budget = 300; rw_check = 1'b0;
        lo_run = 0; busy_cnt = 0;
        dec_q.delete();
        en = 1'b1;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            if (rw_check) begin
                chk("rw_addr", 32'(tape_addr), 32'd0);
                chk("rw_data", 32'(data), 32'd1);
                chk("rw_busy", 32'(busy), 32'd0);
                chk("rw_at_end", 32'(at_end), 32'd0);
                rw_check = 1'b0;
                rewind   = 1'b0;
                en       = 1'b1;
                k        = 0;
                lo_run   = 0;
            end else begin
                if (k < exp_d.size()) begin
                    e_d = exp_d[k]; e_a = exp_a[k]; e_b = 1'b1; e_e = 1'b0;
                end else begin
                    e_d = 1'b1; e_a = tail_a; e_b = 1'b0; e_e = 1'b1;
                end
                chk("data", 32'(data), 32'(e_d));
                chk("busy", 32'(busy), 32'(e_b));
                chk("at_end", 32'(at_end), 32'(e_e));
                chk("addr", 32'(tape_addr), 32'(e_a));
                if (busy) busy_cnt++;
                if (data == 1'b0) begin
                    lo_run++;
                end else if (lo_run > 0) begin
                    dec_q.push_back(lo_run == U);
                    lo_run = 0;
                end
                if (cyc == rewind_at) begin
                    rewind   = 1'b1;
                    en       = 1'b1;
                    rw_check = 1'b1;
                end else begin
                    if (cyc == pause_at) begin
                        pause_left = pause_len;
                    end else if (rand_pause && pause_left == 0 && budget > 0 &&
                                 $urandom_range(0, 39) == 0) begin
                        pause_left = $urandom_range(1, 20);
                        budget     = budget - pause_left;
                    end
                    if (pause_left > 0) begin
                        en = 1'b0;
                        pause_left--;
                    end else begin
                        en = 1'b1;
                        k++;
                    end
                end
            end
        end
        en = 1'b0;
    endtask

    initial begin
        logic [13:0] dec_obs;
        logic [13:0] dec_exp;
        bit          lp;
        int          n;

        reset = 1'b1; rewind = 1'b0; en = 1'b0; loop_en = 1'b0; tape_end = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_addr", 32'(tape_addr), 32'd0);
        chk("reset_data", 32'(data), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_at_end", 32'(at_end), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single 0x00 byte: latency, bit lengths, total frame time, end state
        mem[0] = 8'h00; tape_end = 0; loop_en = 1'b0;
        restart();
        build_model(100000);
        run_play(exp_d.size() + 10, -1, 0, 1'b0, -1);
        chk("t00_busy_cycles", 32'(busy_cnt), 32'(RL + 1 + 9 * 3 * U + 5 * 2 * U));

        // 0xA5: bit order and parity, decoded from the waveform
        mem[0] = 8'hA5;
        restart();
        build_model(100000);
        run_play(exp_d.size() + 10, -1, 0, 1'b0, -1);
        chk("a5_nbits", 32'(dec_q.size()), 32'd14);
        dec_obs = '0;
        foreach (dec_q[i]) dec_obs = {dec_obs[12:0], dec_q[i]};
        dec_exp = 14'b01010010111111;
        chk("a5_bits", 32'(dec_obs), 32'(dec_exp));

        // Three back-to-back bytes
        mem[0] = 8'h01; mem[1] = 8'hFF; mem[2] = 8'h80; tape_end = 2;
        restart();
        build_model(100000);
        run_play(exp_d.size() + 10, -1, 0, 1'b0, -1);

        // 37-cycle pause in the LO of bit 3 of a 0x00 byte
        mem[0] = 8'h00; tape_end = 0;
        restart();
        build_model(100000);
        run_play(exp_d.size() + 47, 45, 37, 1'b0, -1);
        chk("pause_busy_cycles", 32'(busy_cnt), 32'(RL + 1 + 9 * 3 * U + 5 * 2 * U + 37));

        // Loop mode over two bytes
        mem[0] = 8'($urandom); mem[1] = 8'($urandom); tape_end = 1; loop_en = 1'b1;
        restart();
        build_model(900);
        run_play(700, -1, 0, 1'b0, -1);
        loop_en = 1'b0;

        // Rewind together with en in the middle of the first frame
        mem[0] = 8'($urandom); mem[1] = 8'($urandom); mem[2] = 8'($urandom); tape_end = 2;
        restart();
        build_model(100000);
        run_play(exp_d.size() + 82, -1, 0, 1'b0, 70);

        // Randomised tapes, loop settings and pauses
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 4; a++) mem[a] = 8'($urandom);
            tape_end = AW'($urandom_range(0, 3));
            lp       = 1'($urandom_range(0, 1));
            loop_en  = lp;
            restart();
            build_model(lp ? 2000 : 100000);
            n = lp ? 500 : exp_d.size() + 340;
            run_play(n, -1, 0, 1'b1, -1);
        end
        loop_en = 1'b0;

        // Asynchronous reset during the start-bit HI of byte 1
        mem[0] = 8'h00; mem[1] = 8'($urandom); tape_end = 1;
        restart();
        build_model(100000);
        run_play(152, -1, 0, 1'b0, -1);
        #2 reset = 1'b1;
        #1;
        chk("areset_addr", 32'(tape_addr), 32'd0);
        chk("areset_data", 32'(data), 32'd1);
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_at_end", 32'(at_end), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
